// File: rtl/modulo_buffer_registrador_pkg.sv
// Shared sizing for the buffer/holding-register block and the counter datapath.
package modulo_buffer_registrador_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 4;
    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

endpackage : modulo_buffer_registrador_pkg

// File: rtl/modulo_buffer_registrador_fifo.sv
// FIFO storage and pointer bookkeeping. The caller decides push/pop legality;
// this core only moves pointers and occupancy. The head entry is read
// combinationally from storage, so the caller can capture it on the pop edge.
module modulo_fifo_core
    import modulo_buffer_registrador_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    // Next-state: pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards contents logically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));

endmodule : modulo_fifo_core

// File: rtl/modulo_buffer_registrador.sv
// Input FIFO plus holding register feeding the counter datapath.
// The holding register refills from the FIFO head whenever it is empty or the
// counter FSM releases it with Clear_Reg. There is no bypass: a value always
// spends at least one cycle in the FIFO before reaching data_reg.
module modulo_buffer_registrador
    import modulo_buffer_registrador_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    Clear_Reg,
    output logic [DATA_W-1:0]       data_reg,
    output logic                    Load_Reg,
    output logic                    EmptyBuffer,
    output logic                    FullBuffer,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] data_reg_q, data_reg_d;
    logic              load_reg_q, load_reg_d;
    logic              overflow_q, overflow_d;

    logic              fifo_push, fifo_pop;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic [PTR_W:0]    fifo_count;

    // Pop/push decisions; a full FIFO still accepts a write if it pops too.
    always_comb begin
        fifo_pop   = enable && !fifo_empty && (!load_reg_q || Clear_Reg);
        fifo_push  = enable && wr_en && (!fifo_full || fifo_pop);
        overflow_d = enable && wr_en && fifo_full && !fifo_pop;
    end

    // Holding register: refill on pop, release when cleared with nothing queued.
    always_comb begin
        data_reg_d = data_reg_q;
        load_reg_d = load_reg_q;
        if (fifo_pop) begin
            data_reg_d = fifo_head;
            load_reg_d = 1'b1;
        end else if (enable && Clear_Reg) begin
            load_reg_d = 1'b0;
        end
    end

    // Holding register and overflow pulse flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg_q <= '0;
            load_reg_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            data_reg_q <= data_reg_d;
            load_reg_q <= load_reg_d;
            overflow_q <= overflow_d;
        end
    end

    modulo_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (data_in),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign data_reg    = data_reg_q;
    assign Load_Reg    = load_reg_q;
    assign overflow    = overflow_q;
    assign count       = fifo_count;
    assign EmptyBuffer = fifo_empty;
    assign FullBuffer  = fifo_full;

endmodule : modulo_buffer_registrador

// File: tb/tb_modulo_buffer_registrador.sv
// Directed vector bench for modulo_buffer_registrador (DATA_W=4, DEPTH=4).
module tb_modulo_buffer_registrador;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] data_in = '0;
    logic       Clear_Reg = 1'b0;
    logic [3:0] data_reg;
    logic       Load_Reg, EmptyBuffer, FullBuffer, overflow;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    modulo_buffer_registrador #(.DATA_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .data_in(data_in),
        .Clear_Reg(Clear_Reg), .data_reg(data_reg), .Load_Reg(Load_Reg),
        .EmptyBuffer(EmptyBuffer), .FullBuffer(FullBuffer), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, wr, clr;
        logic [3:0] din;
        logic [3:0] e_data;
        logic       e_load, e_empty, e_full, e_ovf;
        logic [2:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic wr, input logic [3:0] din, input logic clr,
                       input logic [3:0] e_data, input logic e_load, input logic [2:0] e_count,
                       input logic e_empty, input logic e_full, input logic e_ovf);
        vec_t v;
        v.en = en; v.wr = wr; v.din = din; v.clr = clr;
        v.e_data = e_data; v.e_load = e_load; v.e_count = e_count;
        v.e_empty = e_empty; v.e_full = e_full; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] d, input logic ld,
                           input logic [2:0] c, input logic em, input logic fu, input logic ov);
        chk({tag, " data_reg"},    int'(data_reg),    int'(d));
        chk({tag, " Load_Reg"},    int'(Load_Reg),    int'(ld));
        chk({tag, " count"},       int'(count),       int'(c));
        chk({tag, " EmptyBuffer"}, int'(EmptyBuffer), int'(em));
        chk({tag, " FullBuffer"},  int'(FullBuffer),  int'(fu));
        chk({tag, " overflow"},    int'(overflow),    int'(ov));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic wr, input logic [3:0] din, input logic clr);
        @(negedge clk);
        enable = en; wr_en = wr; data_in = din; Clear_Reg = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   en wr din  clr  data ld cnt em fu ov
        add(1, 1, 4'h5, 0, 4'h0, 0, 1, 0, 0, 0); // write into empty FIFO
        add(1, 0, 4'h0, 0, 4'h5, 1, 0, 1, 0, 0); // no bypass: loaded one edge later
        add(1, 1, 4'h3, 0, 4'h5, 1, 1, 0, 0, 0);
        add(1, 1, 4'h7, 0, 4'h5, 1, 2, 0, 0, 0);
        add(1, 1, 4'h9, 0, 4'h5, 1, 3, 0, 0, 0);
        add(1, 1, 4'hA, 0, 4'h5, 1, 4, 0, 1, 0); // full
        add(1, 1, 4'hB, 0, 4'h5, 1, 4, 0, 1, 1); // dropped, overflow pulse
        add(1, 0, 4'h0, 0, 4'h5, 1, 4, 0, 1, 0); // pulse only one cycle
        add(1, 1, 4'hC, 1, 4'h3, 1, 4, 0, 1, 0); // pop + write when full
        add(1, 0, 4'h0, 1, 4'h7, 1, 3, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'h9, 1, 2, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'hA, 1, 1, 0, 0, 0);
        add(1, 0, 4'h0, 1, 4'hC, 1, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 4'hC, 0, 0, 1, 0, 0); // clear with empty FIFO releases
        add(1, 0, 4'h0, 1, 4'hC, 0, 0, 1, 0, 0); // again: no effect
        add(1, 1, 4'h1, 0, 4'hC, 0, 1, 0, 0, 0);
        add(1, 1, 4'h2, 0, 4'h1, 1, 1, 0, 0, 0); // pop 1, push 2
        add(0, 1, 4'h8, 1, 4'h1, 1, 1, 0, 0, 0); // enable low: frozen
        add(0, 1, 4'h8, 1, 4'h1, 1, 1, 0, 0, 0);
        add(0, 1, 4'h8, 1, 4'h1, 1, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h1, 1, 1, 0, 0, 0); // held, no clear: no pop

        // Reset state, applied asynchronously before any clock edge.
        #2 rst = 1'b1;
        #1 chk_all("reset", 4'h0, 0, 3'd0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].wr, vecs[i].din, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_load,
                    vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf);
        end

        // Asynchronous reset mid-operation with count=2, Load_Reg=1.
        step(1, 1, 4'h4, 0);
        chk_all("pre_rst", 4'h1, 1, 3'd2, 0, 0, 0);
        @(negedge clk);
        wr_en = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 4'h0, 0, 3'd0, 1, 0, 0);
        #1 rst = 1'b0;
        step(1, 1, 4'h6, 0);
        chk_all("post_rst_w", 4'h0, 0, 3'd1, 0, 0, 0);
        step(1, 0, 4'h0, 0);
        chk_all("post_rst_ld", 4'h6, 1, 3'd0, 1, 0, 0);

        // 2*DEPTH+1 writes interleaved with Clear_Reg; pointers wrap twice.
        // First edge: empty FIFO + clear releases the register, value queued.
        step(1, 1, 4'h1, 1);
        chk_all("wrap0", 4'h6, 0, 3'd1, 0, 0, 0);
        for (int k = 2; k <= 9; k++) begin
            step(1, 1, 4'(k), 1);
            chk_all($sformatf("wrap%0d", k - 1), 4'(k - 1), 1, 3'd1, 0, 0, 0);
        end
        step(1, 0, 4'h0, 1);
        chk_all("wrap_last", 4'h9, 1, 3'd0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_modulo_buffer_registrador
